// File: rtl/pcihellocore_pio_edge_in.sv
// Avalon-MM input port: synchronised WIDTH-bit input with sticky per-bit edge capture and masked level irq.
// Optional PIO_EDGE_COUNT_EN adds a 16-bit saturating edge-event counter at word address 1.
module pcihellocore_pio_edge_in #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_TYPE   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   input  logic [WIDTH-1:0]  in_port,
   output logic [31:0]       readdata,
   output logic              irq
);

   localparam int unsigned PRIME_MAX = SYNC_STAGES + 1;
   localparam int unsigned PRIME_W   = 3;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  sync_in;
   logic [WIDTH-1:0]                  prev;
   logic [WIDTH-1:0]                  rise;
   logic [WIDTH-1:0]                  fall;
   logic [WIDTH-1:0]                  det;
   logic [WIDTH-1:0]                  clr;
   logic [WIDTH-1:0]                  edge_capture;
   logic [WIDTH-1:0]                  irqmask;
   logic [PRIME_W-1:0]                prime_cnt;
   logic                              primed;
   logic                              wr_en;
   logic [31:0]                       rd_mux;

   assign sync_in = sync_q[SYNC_STAGES-1];
   assign primed  = (prime_cnt == PRIME_W'(PRIME_MAX));
   assign wr_en   = chipselect & ~write_n;
   assign clr     = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   // Input synchroniser and previous-sample register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         prev   <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
         prev   <= sync_in;
      end
   end

   // Prime guard: blocks detection until the synchroniser and prev hold real samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prime_cnt <= '0;
      end else if (!primed) begin
         prime_cnt <= prime_cnt + PRIME_W'(1);
      end
   end

   always_comb begin
      rise = sync_in & ~prev;
      fall = ~sync_in & prev;
      det  = '0;
      if (primed) begin
         case (EDGE_TYPE)
            0:       det = rise;
            1:       det = fall;
            default: det = rise | fall;
         endcase
      end
   end

   // Sticky capture (set beats a simultaneous write-1-to-clear) and irq mask
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_capture <= '0;
         irqmask      <= '0;
      end else begin
         edge_capture <= det | (edge_capture & ~clr);
         if (wr_en && address == 2'd2) begin
            irqmask <= writedata[WIDTH-1:0];
         end
      end
   end

   assign irq = |(edge_capture & irqmask);

`ifdef PIO_EDGE_COUNT_EN
   logic [15:0] event_cnt;

   // Saturating count of cycles with any detected edge; a write restarts it, keeping a same-cycle event
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         event_cnt <= '0;
      end else if (wr_en && address == 2'd1) begin
         event_cnt <= {15'd0, |det};
      end else if (|det && event_cnt != 16'hFFFF) begin
         event_cnt <= event_cnt + 16'd1;
      end
   end
`endif

   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0: rd_mux = 32'(sync_in);
`ifdef PIO_EDGE_COUNT_EN
         2'd1: rd_mux = 32'(event_cnt);
`else
         2'd1: rd_mux = '0;
`endif
         2'd2: rd_mux = 32'(irqmask);
         default: rd_mux = 32'(edge_capture);
      endcase
   end

   // Read data registered every cycle regardless of chipselect
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_pcihellocore_pio_edge_in.sv
// Bench for pcihellocore_pio_edge_in: two configurations driven in parallel and checked against a history-based model.
module tb_pcihellocore_pio_edge_in;

`ifdef PIO_EDGE_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] in_port;
   logic [31:0] rd0, rd1;
   logic        irq0, irq1;

   int n_checks = 0;
   int n_errors = 0;

   // model state per configuration: [0] WIDTH 32 / 2 stages / rising, [1] WIDTH 8 / 3 stages / either edge
   int unsigned p_w [2];
   int unsigned p_s [2];
   int unsigned p_e [2];
   logic [31:0] m_hist [2][4];
   int unsigned m_age [2];
   logic [31:0] m_cap [2];
   logic [31:0] m_mask [2];
   logic [15:0] m_cnt [2];
   logic [31:0] m_rd [2];

   always #5 clk = ~clk;

   pcihellocore_pio_edge_in #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd0), .irq(irq0));

   pcihellocore_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2)) dut1 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port[7:0]),
      .readdata(rd1), .irq(irq1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic m_irq(input int i);
      return |(m_cap[i] & m_mask[i]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 4; j++) m_hist[i][j] = '0;
         m_age[i] = 0; m_cap[i] = '0; m_mask[i] = '0; m_cnt[i] = '0; m_rd[i] = '0;
      end
   endtask

   // Advance the model across one clock edge using the inputs currently driven
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         logic [31:0] wm, sy, pv, det, clr;
         logic        wr;
         wm  = (p_w[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << p_w[i]) - 32'd1);
         sy  = m_hist[i][p_s[i]-1];
         pv  = m_hist[i][p_s[i]];
         if (p_e[i] == 0)      det = sy & ~pv;
         else if (p_e[i] == 1) det = ~sy & pv;
         else                  det = sy ^ pv;
         if (m_age[i] < p_s[i] + 1) det = '0;
         case (address)
            2'd0: m_rd[i] = sy;
            2'd1: m_rd[i] = CNT_EN ? {16'd0, m_cnt[i]} : 32'd0;
            2'd2: m_rd[i] = m_mask[i];
            default: m_rd[i] = m_cap[i];
         endcase
         wr  = chipselect && !write_n;
         clr = (wr && address == 2'd3) ? (writedata & wm) : 32'd0;
         m_cap[i] = det | (m_cap[i] & ~clr);
         if (wr && address == 2'd2) m_mask[i] = writedata & wm;
         if (wr && address == 2'd1)               m_cnt[i] = (det != 0) ? 16'd1 : 16'd0;
         else if (det != 0 && m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
         for (int j = 3; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
         m_hist[i][0] = in_port & wm;
         if (m_age[i] < 100) m_age[i]++;
      end
   endtask

   // One clock: model advance, then compare both DUTs at the falling edge
   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      chk("rd0", rd0, m_rd[0]);
      chk("rd1", rd1, m_rd[1]);
      chk("irq0", {31'd0, irq0}, {31'd0, m_irq(0)});
      chk("irq1", {31'd0, irq1}, {31'd0, m_irq(1)});
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_clear();
      #1;
      chk("rst_rd0", rd0, 32'd0);
      chk("rst_rd1", rd1, 32'd0);
      chk("rst_irq0", {31'd0, irq0}, 32'd0);
      chk("rst_irq1", {31'd0, irq1}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      step();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   initial begin
      p_w = '{32, 8}; p_s = '{2, 3}; p_e = '{0, 2};
      reset = 1'b1; address = 2'd3; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = 32'hFFFF_FFFF;
      model_clear();
      @(negedge clk);

      // high input at reset release must not capture
      do_reset();
      for (int k = 0; k < 20; k++) begin
         step();
         chk("prime_irq0", {31'd0, irq0}, 32'd0);
      end
      chk("prime_cap0", rd0, 32'd0);
      chk("prime_cap1", rd1, 32'd0);
      address = 2'd0;
      step();
      chk("data0", rd0, 32'hFFFF_FFFF);
      chk("data1", rd1, 32'h0000_00FF);

      // rising edge on bit0 with mask bit0
      in_port = '0;
      steps(6);
      wr(2'd3, 32'hFFFF_FFFF);
      wr(2'd2, 32'h1);
      address = 2'd3;
      steps(4);
      in_port = 32'h1;
      step(); chk("rise_e1", {31'd0, irq0}, 32'd0);
      step(); chk("rise_e2", {31'd0, irq0}, 32'd0);
      step(); chk("rise_e3", {31'd0, irq0}, 32'd1);
      step(); chk("rise_cap", rd0, 32'h1);
      wr(2'd3, 32'h1);
      steps(2);
      in_port = '0;
      steps(6);
      chk("fall_nocap", rd0, 32'd0);
      chk("fall_noirq", {31'd0, irq0}, 32'd0);

      // clear coinciding with a fresh detect: set wins
      in_port = 32'h1; steps(6);
      in_port = '0;    steps(6);
      in_port = 32'h1; steps(2);
      wr(2'd3, 32'h1);
      chk("setwin_irq", {31'd0, irq0}, 32'd1);
      step();
      chk("setwin_cap", rd0, 32'h1);
      wr(2'd3, 32'h1);
      chk("clr_irqdrop", {31'd0, irq0}, 32'd0);

      // masking of captured bits 3 and 7
      wr(2'd2, 32'h0);
      wr(2'd3, 32'hFFFF_FFFF);
      in_port = 32'h88;
      address = 2'd3;
      steps(6);
      chk("mask0_irq", {31'd0, irq0}, 32'd0);
      chk("mask0_cap", rd0, 32'h88);
      wr(2'd2, 32'h80);
      chk("mask80_irq", {31'd0, irq0}, 32'd1);
      wr(2'd3, 32'h80);
      chk("clr80_irq", {31'd0, irq0}, 32'd0);
      step();
      chk("clr80_cap", rd0, 32'h08);

      // narrow instance, either edge on bit 5
      in_port = '0;
      steps(8);
      wr(2'd3, 32'hFFFF_FFFF);
      address = 2'd3;
      in_port = 32'h20;
      steps(8);
      chk("w8_cap", rd1, 32'h20);
      wr(2'd2, 32'hFF);
      chk("w8_irq", {31'd0, irq1}, 32'd1);

      // reset mid-run clears everything
      in_port = '0;
      do_reset();
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         step();
         chk("post_rst_rd0", rd0, 32'd0);
         chk("post_rst_rd1", rd1, 32'd0);
      end

      // address 1 behaviour
      wr(2'd1, 32'hDEAD_BEEF);
      address = 2'd1;
      steps(2);

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) in_port = $urandom;
         address    = 2'($urandom_range(0, 3));
         chipselect = ($urandom_range(0, 3) == 0);
         write_n    = ($urandom_range(0, 1) == 0);
         writedata  = ($urandom_range(0, 1) == 0) ? $urandom : (32'd1 << $urandom_range(0, 31));
         step();
      end
      chipselect = 1'b0; write_n = 1'b1;

`ifdef PIO_EDGE_COUNT_EN
      // counter saturation and clear alongside an event
      wr(2'd1, 32'h0);
      address = 2'd1;
      for (int k = 0; k < 70000; k++) begin
         in_port = in_port ^ 32'h1;
         step();
      end
      chk("cnt_sat", rd1, 32'h0000_FFFF);
      in_port = in_port ^ 32'h1;
      wr(2'd1, 32'h0);
      in_port = in_port ^ 32'h1;
      step();
      chk("cnt_clr_evt", rd1, 32'h1);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
